mulu_seq: RTL and testbench
===========================

MULU_SEQ -- requirements
Module: mulu_seq

Interface
REQ-001 SHALL have parameter X_WIDTH, default 4: multiplicand width in bits, legal range 2..16.
REQ-002 SHALL have parameter Y_WIDTH, default 4: multiplier width in bits, legal range 2..16; it also sets the iteration count.
REQ-003 SHALL have port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset; asserted when 0.
REQ-005 SHALL have port start, input, 1: request to capture x/y and begin a multiply.
REQ-006 SHALL have port x, input, X_WIDTH: multiplicand.
REQ-007 SHALL have port y, input, Y_WIDTH: multiplier.
REQ-008 SHALL have port p, output, X_WIDTH+Y_WIDTH: registered product.
REQ-009 SHALL have port rdy, output, 1: p holds a valid result.
REQ-010 SHALL have port busy, output, 1: a multiply is in progress.
REQ-011 SHALL have port sgn, input, 1 (MULU_SEQ_SIGNED_EN only): x and y are two's complement.
REQ-012 SHALL have port s, output, 1 (MULU_SEQ_SIGNED_EN only): product is negative.

Function
REQ-013 SHALL implement a three-state FSM: IDLE -> RUN on start; RUN -> DONE after Y_WIDTH iterations; DONE -> RUN on start; no other transitions.
REQ-014 SHALL accept start only in IDLE or DONE; start in RUN is ignored and does not corrupt the operation.
REQ-015 SHALL capture x, y (and sgn) on the accepting edge t0, clear the accumulator and iteration counter, deassert rdy and assert busy after t0.
REQ-016 SHALL perform one shift-add step per RUN cycle, LSB of the multiplier first: add the shifted multiplicand when the bit is 1.
REQ-017 SHALL enter DONE at edge t0+Y_WIDTH, loading p and asserting rdy and deasserting busy at that same edge; latency is exactly Y_WIDTH cycles.
REQ-018 SHALL hold p and rdy in DONE indefinitely until the next accepted start.
REQ-019 SHALL hold the previous p value throughout RUN; p changes only on entry to DONE.
REQ-020 SHALL deassert rdy on the edge that accepts a new start in DONE; back-to-back operations incur no idle cycle.
REQ-021 SHALL compute the unsigned product exactly; X_WIDTH+Y_WIDTH bits never overflow.
REQ-022 SHALL ensure that rdy and busy are never high simultaneously.

Reset
REQ-023 SHALL, while reset=0 at any time including mid-RUN, force FSM=IDLE, p=0, rdy=0, busy=0, s=0, and clear the counter and accumulator immediately and asynchronously.
REQ-024 SHALL ignore start in the first edge where reset is already deasserted only if reset release and that edge coincide; otherwise start is accepted normally.

Configuration
REQ-025 SHALL, with MULU_SEQ_SIGNED_EN defined, and sgn=1 at t0: multiply operand magnitudes, negate the result on entry to DONE when the operand signs differ, and drive s = sign(x) XOR sign(y) AND product!=0; latency is unchanged.
REQ-026 SHALL, with MULU_SEQ_SIGNED_EN defined: produce the most negative magnitude (-2^(W-1)) correctly; p is the two's-complement product in X_WIDTH+Y_WIDTH bits.
REQ-027 SHALL, without MULU_SEQ_SIGNED_EN defined: omit sgn and s ports and all negation logic; the block is unsigned only.

Structure
REQ-028 SHALL place the FSM state encoding (IDLE/RUN/DONE), the counter width function clog2(Y_WIDTH+1), and default width constants in the shared mulu_seq package/header.
REQ-029 SHALL split into a controller sub-module mulu_seq_ctrl (FSM, counter, rdy/busy) plus shift-add datapath in mulu_seq.

Verification
REQ-030 SHALL verify the basic multiply: x=7, y=5, start 1 cycle -> rdy after exactly 4 cycles, p=35, busy high for 4 cycles.
REQ-031 SHALL verify the maximum operands: x=15, y=15 -> p=225 (8'hE1), with no overflow.
REQ-032 SHALL verify that start is ignored in RUN and back-to-back operation works: start held high for 10 cycles with x=3, y=2 then x=9 -> first p=6; second operation begins at the DONE edge with the captured operands; rdy is never high together with busy.
REQ-033 SHALL verify reset mid-RUN: reset=0 at cycle 2 of RUN -> p=0, rdy=0, busy=0 immediately; a following start with x=2, y=3 gives p=6.
REQ-034 SHALL verify signed mode (MULU_SEQ_SIGNED_EN): sgn=1, x=-3, y=5 -> p=8'hF1, s=1; x=-8, y=-8 -> p=64, s=0; x=0, y=-5 -> p=0, s=0.

Source files
------------

// File: rtl/mulu_seq_pkg.sv
// mulu_seq shared package: FSM state encoding, default operand widths and
// the counter-width helper used by the controller.
package mulu_seq_pkg;

   localparam int X_WIDTH_DEF = 4;
   localparam int Y_WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Smallest r with 2**r >= value; sizes the iteration counter.
   function automatic int clog2(input int value);
      int r;
      r = 32'sd0;
      while ((32'sd1 <<< r) < value) begin
         r = r + 32'sd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mulu_seq_ctrl.sv
// mulu_seq_ctrl: three-state controller (IDLE/RUN/DONE) for the sequential
// multiplier. Owns the iteration counter and the registered rdy/busy flags,
// and tells the datapath when to capture operands, step and finish.
module mulu_seq_ctrl
   import mulu_seq_pkg::*;
#(
   parameter int Y_WIDTH = Y_WIDTH_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic load,
   output logic step,
   output logic last,
   output logic rdy,
   output logic busy
);

   localparam int CNT_W = clog2(Y_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Y_WIDTH - 1);

   state_t           state_r, state_nx_s;
   logic [CNT_W-1:0] cnt_r, cnt_nx_s;
   logic             rdy_r, rdy_nx_s;
   logic             busy_r, busy_nx_s;
   logic             load_s;

   // State, counter and status flags; reset clears everything at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         rdy_r   <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
         rdy_r   <= rdy_nx_s;
         busy_r  <= busy_nx_s;
      end
   end

   // Next-state logic: start is only honoured outside RUN.
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      rdy_nx_s   = rdy_r;
      busy_nx_s  = busy_r;
      load_s     = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nx_s = ST_RUN;
               cnt_nx_s   = '0;
               rdy_nx_s   = 1'b0;
               busy_nx_s  = 1'b1;
               load_s     = 1'b1;
            end else begin
               state_nx_s = state_r;
            end
         end
         ST_RUN: begin
            if (cnt_r == CNT_LAST) begin
               state_nx_s = ST_DONE;
               rdy_nx_s   = 1'b1;
               busy_nx_s  = 1'b0;
            end else begin
               cnt_nx_s = cnt_r + CNT_W'(1);
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = '0;
            rdy_nx_s   = 1'b0;
            busy_nx_s  = 1'b0;
         end
      endcase
   end

   assign load = load_s;
   assign step = (state_r == ST_RUN);
   assign last = (state_r == ST_RUN) && (cnt_r == CNT_LAST);
   assign rdy  = rdy_r;
   assign busy = busy_r;

endmodule

// File: rtl/mulu_seq.sv
// mulu_seq: sequential shift-add multiplier, one multiplier bit per cycle,
// LSB first; result appears exactly Y_WIDTH cycles after the accepting edge.
// Optional feature macro: MULU_SEQ_SIGNED_EN adds the sgn/s ports and
// two's-complement operation (magnitudes multiplied, result negated at the end).
module mulu_seq
   import mulu_seq_pkg::*;
#(
   parameter int X_WIDTH = X_WIDTH_DEF,
   parameter int Y_WIDTH = Y_WIDTH_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [X_WIDTH-1:0]         x,
   input  logic [Y_WIDTH-1:0]         y,
`ifdef MULU_SEQ_SIGNED_EN
   input  logic                       sgn,
   output logic                       s,
`endif
   output logic [X_WIDTH+Y_WIDTH-1:0] p,
   output logic                       rdy,
   output logic                       busy
);

   localparam int P_W = X_WIDTH + Y_WIDTH;

   logic               load_s, step_s, last_s;
   logic [X_WIDTH-1:0] x_mag_s;
   logic [Y_WIDTH-1:0] y_mag_s;
   logic [P_W-1:0]     mcand_r;
   logic [Y_WIDTH-1:0] mplier_r;
   logic [P_W-1:0]     acc_r, acc_next_s, p_next_s, p_r;
`ifdef MULU_SEQ_SIGNED_EN
   logic               neg_s, neg_r, s_r;
`endif

   mulu_seq_ctrl #(
      .Y_WIDTH(Y_WIDTH)
   ) u_ctrl (
      .clk  (clk),
      .reset(reset),
      .start(start),
      .load (load_s),
      .step (step_s),
      .last (last_s),
      .rdy  (rdy),
      .busy (busy)
   );

   // Operand magnitudes to capture; in signed mode negatives are flipped so the
   // core loop is always unsigned (most negative value maps to 2**(W-1)).
   always_comb begin
      x_mag_s = x;
      y_mag_s = y;
`ifdef MULU_SEQ_SIGNED_EN
      neg_s = 1'b0;
      if (sgn) begin
         if (x[X_WIDTH-1]) begin
            x_mag_s = -x;
         end else begin
            x_mag_s = x;
         end
         if (y[Y_WIDTH-1]) begin
            y_mag_s = -y;
         end else begin
            y_mag_s = y;
         end
         neg_s = x[X_WIDTH-1] ^ y[Y_WIDTH-1];
      end else begin
         neg_s = 1'b0;
      end
`endif
   end

   // One shift-add step: add the shifted multiplicand when the current bit is 1.
   always_comb begin
      acc_next_s = acc_r;
      if (mplier_r[0]) begin
         acc_next_s = acc_r + mcand_r;
      end else begin
         acc_next_s = acc_r;
      end
`ifdef MULU_SEQ_SIGNED_EN
      if (neg_r) begin
         p_next_s = -acc_next_s;
      end else begin
         p_next_s = acc_next_s;
      end
`else
      p_next_s = acc_next_s;
`endif
   end

   // Datapath registers: capture on accept, iterate in RUN, publish p on the last step.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand_r  <= '0;
         mplier_r <= '0;
         acc_r    <= '0;
         p_r      <= '0;
`ifdef MULU_SEQ_SIGNED_EN
         neg_r    <= 1'b0;
         s_r      <= 1'b0;
`endif
      end else if (load_s) begin
         mcand_r  <= {{Y_WIDTH{1'b0}}, x_mag_s};
         mplier_r <= y_mag_s;
         acc_r    <= '0;
`ifdef MULU_SEQ_SIGNED_EN
         neg_r    <= neg_s;
`endif
      end else if (step_s) begin
         acc_r    <= acc_next_s;
         mcand_r  <= {mcand_r[P_W-2:0], 1'b0};
         mplier_r <= {1'b0, mplier_r[Y_WIDTH-1:1]};
         if (last_s) begin
            p_r <= p_next_s;
`ifdef MULU_SEQ_SIGNED_EN
            s_r <= neg_r && (acc_next_s != '0);
`endif
         end else begin
            p_r <= p_r;
         end
      end else begin
         acc_r <= acc_r;
      end
   end

   assign p = p_r;
`ifdef MULU_SEQ_SIGNED_EN
   assign s = s_r;
`endif

endmodule

// File: tb/tb_mulu_seq.sv
// Directed self-checking bench for mulu_seq (default 4x4 configuration).
module tb_mulu_seq;

   logic       clk;
   logic       reset;
   logic       start;
   logic [3:0] x;
   logic [3:0] y;
   logic [7:0] p;
   logic       rdy;
   logic       busy;
`ifdef MULU_SEQ_SIGNED_EN
   logic       sgn;
   logic       s;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] last_p;

   mulu_seq #(.X_WIDTH(4), .Y_WIDTH(4)) dut (
      .clk  (clk),
      .reset(reset),
      .start(start),
      .x    (x),
      .y    (y),
`ifdef MULU_SEQ_SIGNED_EN
      .sgn  (sgn),
      .s    (s),
`endif
      .p    (p),
      .rdy  (rdy),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start one multiply and follow it to DONE, checking latency and hold of p.
   task automatic run_mul(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp);
      int n;
      x = a;
      y = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, ".busy0"}, 16'(busy), 16'd1);
      chk({tag, ".rdy0"}, 16'(rdy), 16'd0);
      n = 0;
      do begin
         if (rdy !== 1'b1) chk({tag, ".hold"}, 16'(p), 16'(last_p));
         tick();
         n++;
         chk({tag, ".excl"}, 16'(rdy & busy), 16'd0);
      end while (rdy !== 1'b1 && n < 20);
      chk({tag, ".lat"}, 16'(n), 16'd4);
      chk({tag, ".p"}, 16'(p), 16'(exp));
      chk({tag, ".busy"}, 16'(busy), 16'd0);
      last_p = exp;
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      x = 4'd0;
      y = 4'd0;
      last_p = 8'd0;
`ifdef MULU_SEQ_SIGNED_EN
      sgn = 1'b0;
`endif
      tick();
      tick();
      chk("rst.p", 16'(p), 16'd0);
      chk("rst.rdy", 16'(rdy), 16'd0);
      chk("rst.busy", 16'(busy), 16'd0);
      reset = 1'b1;
      tick();
      chk("idle.busy", 16'(busy), 16'd0);

      run_mul("m7x5", 4'd7, 4'd5, 8'd35);
      run_mul("m15x15", 4'd15, 4'd15, 8'hE1);
      // DONE holds p and rdy indefinitely
      repeat (5) tick();
      chk("hold.p", 16'(p), 16'hE1);
      chk("hold.rdy", 16'(rdy), 16'd1);

      // start held 10 cycles: ignored in RUN, back-to-back from DONE
      x = 4'd3;
      y = 4'd2;
      start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 0) x = 4'd9;
         chk("b2b.excl", 16'(rdy & busy), 16'd0);
         if (i >= 1 && i <= 3) chk("b2b.hold1", 16'(p), 16'hE1);
         if (i == 4) begin
            chk("b2b.p1", 16'(p), 16'd6);
            chk("b2b.rdy1", 16'(rdy), 16'd1);
         end
         if (i == 5) begin
            chk("b2b.busy2", 16'(busy), 16'd1);
            chk("b2b.rdy2", 16'(rdy), 16'd0);
         end
         if (i == 8) chk("b2b.hold2", 16'(p), 16'd6);
         if (i == 9) begin
            chk("b2b.p2", 16'(p), 16'd18);
            chk("b2b.rdy3", 16'(rdy), 16'd1);
         end
      end
      start = 1'b0;
      last_p = 8'd18;

      // reset in the middle of RUN
      x = 4'd5;
      y = 4'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("mrst.p", 16'(p), 16'd0);
      chk("mrst.rdy", 16'(rdy), 16'd0);
      chk("mrst.busy", 16'(busy), 16'd0);
      tick();
      reset = 1'b1;
      last_p = 8'd0;
      tick();
      run_mul("m2x3", 4'd2, 4'd3, 8'd6);

      run_mul("m0x9", 4'd0, 4'd9, 8'd0);
      run_mul("m1x15", 4'd1, 4'd15, 8'd15);
      run_mul("m15x1", 4'd15, 4'd1, 8'd15);
      run_mul("m10x12", 4'd10, 4'd12, 8'd120);
      run_mul("m8x8", 4'd8, 4'd8, 8'd64);

`ifdef MULU_SEQ_SIGNED_EN
      sgn = 1'b1;
      run_mul("sm3x5", 4'hD, 4'd5, 8'hF1);
      chk("sm3x5.s", 16'(s), 16'd1);
      run_mul("sm8xm8", 4'h8, 4'h8, 8'd64);
      chk("sm8xm8.s", 16'(s), 16'd0);
      run_mul("s0xm5", 4'd0, 4'hB, 8'd0);
      chk("s0xm5.s", 16'(s), 16'd0);
      sgn = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
